// File: rtl/nibble_cmp_sequencer_if.sv
// rtl/nibble_cmp_sequencer_if.sv - request/result and comparator-slice signal bundle
// Interface for nibble_cmp_sequencer (parameter W = operand width).
//   Request side : start, a_in, b_in -> busy, done, eq, lt, gt, err
//   Slice side   : sl_a, sl_b, sl_ei, sl_li, sl_gi -> sl_e, sl_l, sl_g
//   slave  : the sequencer
//   master : operand producer plus the external comparator slice
interface nibble_cmp_sequencer_if #(
    parameter int W = 16
) ();
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy;
    logic         done;
    logic         eq;
    logic         lt;
    logic         gt;
    logic         err;
    logic [3:0]   sl_a;
    logic [3:0]   sl_b;
    logic         sl_ei;
    logic         sl_li;
    logic         sl_gi;
    logic         sl_e;
    logic         sl_l;
    logic         sl_g;

    modport slave (
        input  start, a_in, b_in, sl_e, sl_l, sl_g,
        output busy, done, eq, lt, gt, err, sl_a, sl_b, sl_ei, sl_li, sl_gi
    );

    modport master (
        output start, a_in, b_in, sl_e, sl_l, sl_g,
        input  busy, done, eq, lt, gt, err, sl_a, sl_b, sl_ei, sl_li, sl_gi
    );
endinterface

// File: rtl/nibble_cmp_sequencer.sv
// rtl/nibble_cmp_sequencer.sv - multi-nibble compare through one shared cascadable slice
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : nibble_cmp_sequencer_if.slave (W must equal 4*NIB)
// Parameters: NIB (nibbles per operand), SETTLE_CYC (cycles per nibble), SIGNED (1 = two's complement).
// Optional macro CMP_ONEHOT_CHECK_EN: flags non-one-hot slice outputs and reports them on err.
module nibble_cmp_sequencer #(
    parameter int NIB        = 4,
    parameter int SETTLE_CYC = 2,
    parameter int SIGNED     = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    nibble_cmp_sequencer_if.slave   bus
);
    localparam int W    = 4 * NIB;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int CNTW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);
    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t          state;
    state_t          nextState;
    logic [W-1:0]    opA;
    logic [W-1:0]    opB;
    logic [IDXW-1:0] idx;
    logic [CNTW-1:0] cnt;
    logic            cE;
    logic            cL;
    logic            cG;
    logic            doneR;
    logic            eqR;
    logic            ltR;
    logic            gtR;
    logic            finEq;
    logic            finLt;
    logic            finGt;
    logic            startAcc;
    logic            sampleNow;

    assign startAcc  = bus.start && (state == IDLE);
    assign sampleNow = (state == RUN) && (cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (startAcc) nextState = RUN;
            RUN:     if (sampleNow && (idx == LAST_IDX)) nextState = FIN;
            FIN:     nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        bus.busy  = (state != IDLE);
        bus.sl_a  = opA[4*idx +: 4];
        bus.sl_b  = opB[4*idx +: 4];
        bus.sl_ei = cE;
        bus.sl_li = cL;
        bus.sl_gi = cG;
        // The slice chain is unsigned; when signs differ the MSB nibble decided
        // the wrong way round, and cE is already 0, so swapping lt/gt is enough.
        if ((SIGNED != 0) && (opA[W-1] != opB[W-1])) begin
            finEq = 1'b0;
            finLt = ~cL;
            finGt = ~cG;
        end else begin
            finEq = cE;
            finLt = cL;
            finGt = cG;
        end
    end

`ifdef CMP_ONEHOT_CHECK_EN
    logic badFlag;
    logic errR;
    logic sliceOneHot;

    assign sliceOneHot = (bus.sl_e ^ bus.sl_l ^ bus.sl_g) && !(bus.sl_e && bus.sl_l && bus.sl_g);
    assign bus.err     = errR;

    always_ff @(posedge clk) begin
        if (rst) begin
            badFlag <= 1'b0;
            errR    <= 1'b0;
        end else if (startAcc) begin
            badFlag <= 1'b0;
            errR    <= 1'b0;
        end else if (sampleNow && !sliceOneHot) begin
            badFlag <= 1'b1;
        end else if (state == FIN) begin
            errR    <= badFlag;
        end
    end
`else
    logic badFlag;
    assign badFlag = 1'b0;
    assign bus.err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            opA   <= '0;
            opB   <= '0;
            idx   <= '0;
            cnt   <= '0;
            cE    <= 1'b1;
            cL    <= 1'b0;
            cG    <= 1'b0;
            doneR <= 1'b0;
            eqR   <= 1'b0;
            ltR   <= 1'b0;
            gtR   <= 1'b0;
        end else begin
            doneR <= 1'b0;
            if (startAcc) begin
                opA <= bus.a_in;
                opB <= bus.b_in;
                idx <= '0;
                cnt <= '0;
                cE  <= 1'b1;
                cL  <= 1'b0;
                cG  <= 1'b0;
                eqR <= 1'b0;
                ltR <= 1'b0;
                gtR <= 1'b0;
            end else if (state == RUN) begin
                if (sampleNow) begin
                    // Slice outputs are only trusted here, after the settle window.
                    cE  <= bus.sl_e;
                    cL  <= bus.sl_l;
                    cG  <= bus.sl_g;
                    cnt <= '0;
                    if (idx != LAST_IDX) idx <= idx + 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (state == FIN) begin
                doneR <= 1'b1;
                eqR   <= finEq && !badFlag;
                ltR   <= finLt && !badFlag;
                gtR   <= finGt && !badFlag;
            end
        end
    end

    assign bus.done = doneR;
    assign bus.eq   = eqR;
    assign bus.lt   = ltR;
    assign bus.gt   = gtR;
endmodule

// File: tb/tb_nibble_cmp_sequencer.sv
// tb/tb_nibble_cmp_sequencer.sv - self-checking bench for nibble_cmp_sequencer
module tb_nibble_cmp_sequencer;
    logic clk = 1'b0;
    logic rst;
    logic inject = 1'b0;
    int   sCnt = 0;
    int   uCnt = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    nibble_cmp_sequencer_if #(.W(16)) sIf ();
    nibble_cmp_sequencer_if #(.W(16)) uIf ();

    nibble_cmp_sequencer #(.NIB(4), .SETTLE_CYC(2), .SIGNED(1)) dutS (
        .clk (clk),
        .rst (rst),
        .bus (sIf.slave)
    );

    nibble_cmp_sequencer #(.NIB(4), .SETTLE_CYC(2), .SIGNED(0)) dutU (
        .clk (clk),
        .rst (rst),
        .bus (uIf.slave)
    );

    // Cycles since the last accepted start, per DUT.
    always @(posedge clk) begin
        if (sIf.start && !sIf.busy) sCnt <= 0;
        else                        sCnt <= sCnt + 1;
        if (uIf.start && !uIf.busy) uCnt <= 0;
        else                        uCnt <= uCnt + 1;
    end

    // Ideal cascadable 4-bit slices.
    always_comb begin
        sIf.sl_e = 1'b0;
        sIf.sl_l = 1'b0;
        sIf.sl_g = 1'b0;
        if (sIf.sl_a > sIf.sl_b)      sIf.sl_g = 1'b1;
        else if (sIf.sl_a < sIf.sl_b) sIf.sl_l = 1'b1;
        else begin
            sIf.sl_e = sIf.sl_ei;
            sIf.sl_l = sIf.sl_li;
            sIf.sl_g = sIf.sl_gi;
        end
        if (inject && sIf.busy && (sCnt / 2 == 2)) begin
            sIf.sl_e = 1'b1;
            sIf.sl_l = 1'b0;
            sIf.sl_g = 1'b1;
        end
    end

    always_comb begin
        uIf.sl_e = 1'b0;
        uIf.sl_l = 1'b0;
        uIf.sl_g = 1'b0;
        if (uIf.sl_a > uIf.sl_b)      uIf.sl_g = 1'b1;
        else if (uIf.sl_a < uIf.sl_b) uIf.sl_l = 1'b1;
        else begin
            uIf.sl_e = uIf.sl_ei;
            uIf.sl_l = uIf.sl_li;
            uIf.sl_g = uIf.sl_gi;
        end
    end

    function automatic logic [2:0] refCmp(input logic [15:0] a, input logic [15:0] b, input bit sgn);
        int x;
        int y;
        if (sgn) begin
            x = int'($signed(a));
            y = int'($signed(b));
        end else begin
            x = int'({16'h0, a});
            y = int'({16'h0, b});
        end
        return {x == y, x < y, x > y};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Call at a negedge; returns 1ns after the start edge.
    task automatic issueStart(input bit uns, input logic [15:0] a, input logic [15:0] b);
        if (uns) begin
            uIf.a_in = a; uIf.b_in = b; uIf.start = 1'b1;
        end else begin
            sIf.a_in = a; sIf.b_in = b; sIf.start = 1'b1;
        end
        @(posedge clk);
        #1;
        uIf.start = 1'b0;
        sIf.start = 1'b0;
    endtask

    task automatic waitDone(input bit uns, output int lat, output int busySeen);
        lat = -1;
        busySeen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (uns ? uIf.busy : sIf.busy) busySeen++;
            if (uns ? uIf.done : sIf.done) begin
                lat = uns ? uCnt : sCnt;
                break;
            end
        end
    endtask

    task automatic checkResult(input bit uns, input logic [15:0] a, input logic [15:0] b, input string tag);
        logic [2:0] e;
        e = refCmp(a, b, !uns);
        if (uns) begin
            chk({tag, "_eq"}, 32'(uIf.eq), 32'(e[2]));
            chk({tag, "_lt"}, 32'(uIf.lt), 32'(e[1]));
            chk({tag, "_gt"}, 32'(uIf.gt), 32'(e[0]));
            chk({tag, "_err"}, 32'(uIf.err), 32'd0);
        end else begin
            chk({tag, "_eq"}, 32'(sIf.eq), 32'(e[2]));
            chk({tag, "_lt"}, 32'(sIf.lt), 32'(e[1]));
            chk({tag, "_gt"}, 32'(sIf.gt), 32'(e[0]));
            chk({tag, "_err"}, 32'(sIf.err), 32'd0);
        end
    endtask

    task automatic runFull(input bit uns, input logic [15:0] a, input logic [15:0] b, input string tag);
        int lat;
        int bs;
        @(negedge clk);
        issueStart(uns, a, b);
        waitDone(uns, lat, bs);
        chk({tag, "_latency"}, 32'(lat), 32'd9);
        checkResult(uns, a, b, tag);
    endtask

    initial begin
        int lat;
        int bs;
        int doneSeen;
        logic [15:0] ra;
        logic [15:0] rb;

        rst = 1'b1;
        sIf.start = 1'b0; sIf.a_in = '0; sIf.b_in = '0;
        uIf.start = 1'b0; uIf.a_in = '0; uIf.b_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(sIf.busy), 32'd0);
        chk("rst_done", 32'(sIf.done), 32'd0);
        chk("rst_res", 32'({sIf.eq, sIf.lt, sIf.gt, sIf.err}), 32'd0);
        chk("rst_sl_ab", 32'({sIf.sl_a, sIf.sl_b}), 32'd0);
        chk("rst_sl_casc", 32'({sIf.sl_ei, sIf.sl_li, sIf.sl_gi}), 32'b100);
        rst = 1'b0;

        // Equal operands, latency and busy length.
        @(negedge clk);
        issueStart(0, 16'h1234, 16'h1234);
        waitDone(0, lat, bs);
        chk("eq_latency", 32'(lat), 32'd9);
        chk("eq_busy_len", 32'(bs), 32'd9);
        checkResult(0, 16'h1234, 16'h1234, "eq");
        @(negedge clk);
        chk("done_pulse", 32'(sIf.done), 32'd0);
        chk("eq_hold", 32'(sIf.eq), 32'd1);

        runFull(0, 16'hFFFF, 16'h0001, "neg_vs_pos");
        runFull(1, 16'hFFFF, 16'h0001, "uns_ffff");
        runFull(0, 16'h7000, 16'h7001, "nib0_lt");
        runFull(0, 16'h8001, 16'h8000, "nib0_gt");
        runFull(1, 16'h8001, 16'h8000, "uns_nib0_gt");

        // Start while busy is ignored; start in the done cycle is accepted.
        @(negedge clk);
        issueStart(0, 16'h0005, 16'h0003);
        repeat (3) @(negedge clk);
        @(negedge clk);
        issueStart(0, 16'h0001, 16'h0009);
        waitDone(0, lat, bs);
        chk("ign_latency", 32'(lat), 32'd9);
        checkResult(0, 16'h0005, 16'h0003, "ign");
        issueStart(0, 16'h4321, 16'h1234);
        chk("clear_on_start", 32'({sIf.eq, sIf.lt, sIf.gt, sIf.busy}), 32'b0001);
        waitDone(0, lat, bs);
        chk("b2b_latency", 32'(lat), 32'd9);
        checkResult(0, 16'h4321, 16'h1234, "b2b");

        // Reset in the middle of a compare.
        @(negedge clk);
        issueStart(0, 16'h2222, 16'h1111);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", 32'(sIf.busy), 32'd0);
        chk("mid_rst_res", 32'({sIf.done, sIf.eq, sIf.lt, sIf.gt, sIf.err}), 32'd0);
        chk("mid_rst_sl", 32'({sIf.sl_a, sIf.sl_b, sIf.sl_ei, sIf.sl_li, sIf.sl_gi}), 32'b100);
        rst = 1'b0;
        doneSeen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (sIf.done) doneSeen++;
        end
        chk("mid_rst_no_done", 32'(doneSeen), 32'd0);
        runFull(0, 16'h2222, 16'h1111, "after_rst");

        // Randomized operands against the arithmetic model.
        for (int i = 0; i < 24; i++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra ^ (16'hF << (4 * $urandom_range(0, 3)));
                default: rb = 16'($urandom);
            endcase
            runFull(1'($urandom_range(0, 1)), ra, rb, $sformatf("rnd%0d", i));
        end

`ifdef CMP_ONEHOT_CHECK_EN
        inject = 1'b1;
        @(negedge clk);
        issueStart(0, 16'h5A5A, 16'h5A5A);
        waitDone(0, lat, bs);
        inject = 1'b0;
        chk("bad_latency", 32'(lat), 32'd9);
        chk("bad_err", 32'(sIf.err), 32'd1);
        chk("bad_res", 32'({sIf.eq, sIf.lt, sIf.gt}), 32'd0);
        runFull(0, 16'h5A5A, 16'h5A5A, "clean_after_bad");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
